axi4_lite_regbank_slave: RTL and testbench

AXI4-Lite responder that terminates the five AXI4-Lite channels driven by our master, backed by a bank of NUM_REGS software-visible 32-bit registers.
- Accepts write address and write data independently and commits writes with byte strobes.
- Returns OKAY or SLVERR responses; read data is registered.
- Exposes register contents and per-register write pulses to local logic.
- Sits at the far end of the AXI4-Lite link as the peripheral-side control/status block.

---
 rtl/axi4_lite_regbank_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi4_lite_regbank_slave.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regbank_slave.sv
// AXI4-Lite register bank responder.
// Write address and write data are captured into independent one-deep holds and
// committed together once both are present and the previous write response has
// been accepted. Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are
// byte-writable. Reads are answered from a registered data/response pair.
module axi4_lite_regbank_slave #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS       = 8,
    parameter logic [31:0] ID_VALUE       = 32'hA5A5_0001
) (
    input  logic                      clk,
    input  logic                      arst,

    input  logic                      AW_VALID,
    output logic                      AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    input  logic [2:0]                AW_PROT,

    input  logic                      W_VALID,
    output logic                      W_READY,
    input  logic [31:0]               W_DATA,
    input  logic [3:0]                W_STRB,

    output logic                      B_VALID,
    input  logic                      B_READY,
    output logic [1:0]                B_RESP,

    input  logic                      AR_VALID,
    output logic                      AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic [2:0]                AR_PROT,

    output logic                      R_VALID,
    input  logic                      R_READY,
    output logic [31:0]               R_DATA,
    output logic [1:0]                R_RESP,

    output logic [NUM_REGS*32-1:0]    o_regs,
    output logic [NUM_REGS-1:0]       o_wr_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Elaboration-time guard on unsupported parameterisations.
    if (AXI_DATA_WIDTH != 32) begin : g_data_width_check
        $error("axi4_lite_regbank_slave: only 32-bit data is supported");
    end
    if ((NUM_REGS < 2) || (NUM_REGS > 256) || ((1 << IDX_W) != NUM_REGS)) begin : g_num_regs_check
        $error("axi4_lite_regbank_slave: NUM_REGS must be a power of two in 2..256");
    end

    // Write address / data holds.
    logic                      aw_held_q, aw_held_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                      w_held_q, w_held_d;
    logic [31:0]               w_data_q, w_data_d;
    logic [3:0]                w_strb_q, w_strb_d;

    // Write response.
    logic                      b_valid_q, b_valid_d;
    logic [1:0]                b_resp_q, b_resp_d;

    // Read response.
    logic                      r_valid_q, r_valid_d;
    logic [31:0]               r_data_q, r_data_d;
    logic [1:0]                r_resp_q, r_resp_d;

    // Register storage; entry 0 is never written and is replaced by ID_VALUE in the view.
    logic [31:0]               regs_q [NUM_REGS];
    logic [31:0]               regs_d [NUM_REGS];
    logic [31:0]               reg_view [NUM_REGS];
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;

    logic                      aw_hs, w_hs, ar_hs;
    logic                      commit;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      wr_oor, rd_oor;
    logic                      wr_ok;

    // Protection bits and the sub-word address bits carry no meaning here.
    logic                      unused_bits;
    assign unused_bits = ^{AW_PROT, AR_PROT, AR_ADDR[1:0], aw_addr_q[1:0]};

    // Ready signals depend only on internal state, never on an incoming VALID.
    assign AW_READY = !aw_held_q;
    assign W_READY  = !w_held_q;
    assign AR_READY = !r_valid_q;

    assign aw_hs  = AW_VALID & AW_READY;
    assign w_hs   = W_VALID & W_READY;
    assign ar_hs  = AR_VALID & AR_READY;
    assign commit = aw_held_q & w_held_q & !b_valid_q;

    assign wr_idx = aw_addr_q[IDX_W+1:2];
    assign rd_idx = AR_ADDR[IDX_W+1:2];
    assign wr_oor = |aw_addr_q[AXI_ADDR_WIDTH-1:IDX_W+2];
    assign rd_oor = |AR_ADDR[AXI_ADDR_WIDTH-1:IDX_W+2];
    assign wr_ok  = !wr_oor && (wr_idx != '0);

    assign B_VALID    = b_valid_q;
    assign B_RESP     = b_resp_q;
    assign R_VALID    = r_valid_q;
    assign R_DATA     = r_data_q;
    assign R_RESP     = r_resp_q;
    assign o_wr_pulse = wr_pulse_q;

    // Software-visible register view with the read-only ID word in slot 0.
    always_comb begin
        reg_view[0] = ID_VALUE;
        for (int k = 1; k < NUM_REGS; k++) begin
            reg_view[k] = regs_q[k];
        end
    end

    // Flatten the register view onto the local-logic bus.
    always_comb begin
        o_regs = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_regs[k*32 +: 32] = reg_view[k];
        end
    end

    // Capture AW and W independently; a commit frees both holds.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = AW_ADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = W_DATA;
            w_strb_d = W_STRB;
        end
    end

    // Commit a held write into the bank and raise the response.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        wr_pulse_d = '0;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        if (b_valid_q && B_READY) begin
            b_valid_d = 1'b0;
        end
        if (commit) begin
            b_valid_d = 1'b1;
            if (wr_ok) begin
                b_resp_d = RESP_OKAY;
                // A zero strobe still counts as a successful access, so the pulse fires.
                wr_pulse_d[wr_idx] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end else begin
                b_resp_d = RESP_SLVERR;
            end
        end
    end

    // Read response: sampled from the pre-commit view so a same-edge write is not visible.
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (r_valid_q && R_READY) begin
            r_valid_d = 1'b0;
        end
        if (ar_hs) begin
            r_valid_d = 1'b1;
            if (rd_oor) begin
                r_data_d = '0;
                r_resp_d = RESP_SLVERR;
            end else begin
                r_data_d = reg_view[rd_idx];
                r_resp_d = RESP_OKAY;
            end
        end
    end

    // State registers; reset drops any in-flight hold or response.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// Self-checking bench for axi4_lite_regbank_slave: directed scenarios plus a
// randomized mix, all checked against a word-array model of the register bank.
module tb_axi4_lite_regbank_slave;

    localparam int          AW = 64;
    localparam int          NR = 8;
    localparam logic [31:0] ID = 32'hA5A5_0001;

    logic              clk = 1'b0;
    logic              arst = 1'b0;
    logic              AW_VALID = 1'b0, AW_READY;
    logic [AW-1:0]     AW_ADDR = '0;
    logic [2:0]        AW_PROT = 3'b000;
    logic              W_VALID = 1'b0, W_READY;
    logic [31:0]       W_DATA = '0;
    logic [3:0]        W_STRB = '0;
    logic              B_VALID, B_READY = 1'b0;
    logic [1:0]        B_RESP;
    logic              AR_VALID = 1'b0, AR_READY;
    logic [AW-1:0]     AR_ADDR = '0;
    logic [2:0]        AR_PROT = 3'b000;
    logic              R_VALID, R_READY = 1'b0;
    logic [31:0]       R_DATA;
    logic [1:0]        R_RESP;
    logic [NR*32-1:0]  o_regs;
    logic [NR-1:0]     o_wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [NR];
    int          pulse_cnt [NR];

    axi4_lite_regbank_slave dut (
        .clk(clk), .arst(arst),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
        .o_regs(o_regs), .o_wr_pulse(o_wr_pulse)
    );

    always #5 clk = ~clk;

    // Count pulse cycles; sampled at posedge so the value of the ending cycle is seen.
    initial for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
    always @(posedge clk) begin
        for (int k = 0; k < NR; k++) if (o_wr_pulse[k] === 1'b1) pulse_cnt[k]++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
    endfunction

    function automatic logic [33:0] model_read(input logic [AW-1:0] a);
        if (a >= 64'(4 * NR)) return {2'b10, 32'h0};
        if ((a >> 2) == 0) return {2'b00, ID};
        return {2'b00, mdl[int'(a >> 2)]};
    endfunction

    function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int i;
        if (a >= 64'(4 * NR) || (a >> 2) == 0) return 2'b10;
        i = int'(a >> 2);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [NR*32-1:0] exp_regs();
        logic [NR*32-1:0] v;
        v[31:0] = ID;
        for (int k = 1; k < NR; k++) v[k*32 +: 32] = mdl[k];
        return v;
    endfunction

    // ---------------- drivers (inputs change and outputs are sampled at negedge) ----------------
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit send_aw, input bit send_w, input int aw_dly, input int w_dly);
        bit aw_done, w_done, aw_hs, w_hs;
        int t;
        aw_done = !send_aw;
        w_done  = !send_w;
        t = 0;
        if (send_aw) AW_ADDR = a;
        if (send_w) begin W_DATA = d; W_STRB = s; end
        while (!(aw_done && w_done) && t < 100) begin
            AW_VALID = !aw_done && (t >= aw_dly);
            W_VALID  = !w_done && (t >= w_dly);
            aw_hs = AW_VALID && AW_READY;
            w_hs  = W_VALID && W_READY;
            @(negedge clk);
            t++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
        end
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
    endtask

    // lat counts cycles from the last handshake cycle (cycle 0) to B_VALID.
    task automatic wait_b(input int b_dly, output logic [1:0] resp, output int lat);
        lat = 1;
        while (!B_VALID && lat < 50) begin @(negedge clk); lat++; end
        if (!B_VALID) begin lat = -1; resp = 2'bxx; return; end
        resp = B_RESP;
        repeat (b_dly) @(negedge clk);
        B_READY = 1'b1;
        @(negedge clk);
        B_READY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int t;
        AR_ADDR  = a;
        AR_VALID = 1'b1;
        t = 0;
        while (!AR_READY && t < 50) begin @(negedge clk); t++; end
        if (!AR_READY) begin AR_VALID = 1'b0; lat = -1; data = 'x; resp = 'x; return; end
        @(negedge clk);
        AR_VALID = 1'b0;
        lat = 1;
        while (!R_VALID && lat < 50) begin @(negedge clk); lat++; end
        if (!R_VALID) begin lat = -1; data = 'x; resp = 'x; return; end
        data = R_DATA;
        resp = R_RESP;
        repeat (r_dly) @(negedge clk);
        R_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_clear();
        @(negedge clk);
        checks++;
        if ({B_VALID, R_VALID, B_RESP, R_RESP} !== 6'b0) begin
            errors++;
            $display("FAIL reset_resp: got B_VALID=%b R_VALID=%b B_RESP=%b R_RESP=%b, want all 0",
                     B_VALID, R_VALID, B_RESP, R_RESP);
        end
        checks++;
        if (R_DATA !== 32'h0 || o_wr_pulse !== '0) begin
            errors++;
            $display("FAIL reset_data: got R_DATA=%h pulse=%b, want 0", R_DATA, o_wr_pulse);
        end
        checks++;
        if (o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL reset_regs: got %h want %h", o_regs, exp_regs());
        end
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if ({AW_READY, W_READY, AR_READY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b want 111", {AW_READY, W_READY, AR_READY});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp, exp_resp;
        logic [31:0] data;
        logic [33:0] exp_rd;
        int lat;
        exp_resp = model_write(64'h4, 32'h1234_5678, 4'hF);
        axi_write(64'h4, 32'h1234_5678, 4'hF, 1, 1, 0, 0);
        wait_b(0, resp, lat);
        checks++;
        if (resp !== exp_resp || lat != 2) begin
            errors++;
            $display("FAIL basic_write: got resp=%b lat=%0d, want resp=%b lat=2", resp, lat, exp_resp);
        end
        exp_rd = model_read(64'h4);
        axi_read(64'h4, 0, data, resp, lat);
        checks++;
        if ({resp, data} !== exp_rd || lat != 1) begin
            errors++;
            $display("FAIL basic_read: got %b/%h lat=%0d, want %b/%h lat=1",
                     resp, data, lat, exp_rd[33:32], exp_rd[31:0]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp, exp_resp;
        int lat;
        int snap [NR];
        int extra;
        exp_resp = model_write(64'h8, 32'h1111_1111, 4'hF);
        axi_write(64'h8, 32'h1111_1111, 4'hF, 1, 1, 0, 0);
        wait_b(0, resp, lat);
        for (int k = 0; k < NR; k++) snap[k] = pulse_cnt[k];
        axi_write(64'h8, 32'hDEAD_BEEF, 4'b0101, 0, 1, 0, 0);
        checks++;
        if ({W_READY, AW_READY} !== 2'b01) begin
            errors++;
            $display("FAIL w_hold_ready: got W_READY=%b AW_READY=%b, want 0/1", W_READY, AW_READY);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (B_VALID !== 1'b0) begin
            errors++;
            $display("FAIL w_only_no_commit: got B_VALID=%b want 0", B_VALID);
        end
        exp_resp = model_write(64'h8, 32'hDEAD_BEEF, 4'b0101);
        axi_write(64'h8, 32'h0, 4'h0, 1, 0, 0, 0);
        wait_b(0, resp, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (resp !== exp_resp || lat != 2) begin
            errors++;
            $display("FAIL split_write: got resp=%b lat=%0d, want %b lat=2", resp, lat, exp_resp);
        end
        checks++;
        if (o_regs[2*32 +: 32] !== 32'h11AD_11EF || o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL strobe_merge: got reg2=%h want 11ad11ef", o_regs[2*32 +: 32]);
        end
        extra = 0;
        for (int k = 0; k < NR; k++) if (k != 2) extra += pulse_cnt[k] - snap[k];
        checks++;
        if (pulse_cnt[2] - snap[2] != 1 || extra != 0) begin
            errors++;
            $display("FAIL pulse_once: got reg2 pulses=%0d others=%0d, want 1/0",
                     pulse_cnt[2] - snap[2], extra);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] resp, exp_resp;
        logic [31:0] data;
        logic [33:0] exp_rd;
        int lat, total;
        int snap [NR];
        for (int k = 0; k < NR; k++) snap[k] = pulse_cnt[k];
        exp_resp = model_write(64'h0, 32'hCAFE_F00D, 4'hF);
        axi_write(64'h0, 32'hCAFE_F00D, 4'hF, 1, 1, 0, 0);
        wait_b(1, resp, lat);
        exp_resp = exp_resp;
        checks++;
        if (resp !== 2'b10 || lat != 2) begin
            errors++;
            $display("FAIL wr_idx0: got resp=%b lat=%0d, want %b lat=2", resp, lat, exp_resp);
        end
        exp_resp = model_write(64'h40, 32'h5555_AAAA, 4'hF);
        axi_write(64'h40, 32'h5555_AAAA, 4'hF, 1, 1, 0, 0);
        wait_b(0, resp, lat);
        checks++;
        if (resp !== exp_resp) begin
            errors++;
            $display("FAIL wr_oor: got resp=%b want %b", resp, exp_resp);
        end
        repeat (2) @(negedge clk);
        total = 0;
        for (int k = 0; k < NR; k++) total += pulse_cnt[k] - snap[k];
        checks++;
        if (total != 0 || o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL slverr_side_effect: got pulses=%0d regs=%h, want 0 / %h", total, o_regs, exp_regs());
        end
        exp_rd = model_read(64'h0);
        axi_read(64'h0, 0, data, resp, lat);
        checks++;
        if ({resp, data} !== exp_rd) begin
            errors++;
            $display("FAIL rd_id: got %b/%h want %b/%h", resp, data, exp_rd[33:32], exp_rd[31:0]);
        end
        exp_rd = model_read(64'h40);
        axi_read(64'h40, 0, data, resp, lat);
        checks++;
        if ({resp, data} !== exp_rd || lat != 1) begin
            errors++;
            $display("FAIL rd_oor: got %b/%h lat=%0d want %b/%h", resp, data, lat, exp_rd[33:32], exp_rd[31:0]);
        end
        // Zero strobe: OKAY, pulse, no data change.
        for (int k = 0; k < NR; k++) snap[k] = pulse_cnt[k];
        exp_resp = model_write(64'h14, 32'hFFFF_FFFF, 4'h0);
        axi_write(64'h14, 32'hFFFF_FFFF, 4'h0, 1, 1, 0, 0);
        wait_b(0, resp, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (resp !== exp_resp || pulse_cnt[5] - snap[5] != 1 || o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL zero_strobe: got resp=%b pulses=%0d reg5=%h, want %b 1 %h",
                     resp, pulse_cnt[5] - snap[5], o_regs[5*32 +: 32], exp_resp, mdl[5]);
        end
    endtask

    task automatic test_b_backpressure();
        logic [1:0] r1, r2;
        logic [31:0] data;
        logic [1:0] resp;
        logic [33:0] exp_rd;
        int lat;
        bit bad;
        r1 = model_write(64'h0, 32'h0BAD_0BAD, 4'hF);
        axi_write(64'h0, 32'h0BAD_0BAD, 4'hF, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (B_VALID !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_b: got B_VALID=%b want 1", B_VALID);
        end
        axi_write(64'h10, 32'h7654_3210, 4'hF, 1, 1, 0, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (B_VALID !== 1'b1 || B_RESP !== r1 || AW_READY !== 1'b0 || W_READY !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: B_VALID=%b B_RESP=%b AW_READY=%b W_READY=%b, want 1/%b/0/0",
                     B_VALID, B_RESP, AW_READY, W_READY, r1);
        end
        r2 = model_write(64'h10, 32'h7654_3210, 4'hF);
        B_READY = 1'b1;
        @(negedge clk);
        B_READY = 1'b0;
        checks++;
        if (B_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap: got B_VALID=%b want 0 one cycle after B handshake", B_VALID);
        end
        @(negedge clk);
        checks++;
        if (B_VALID !== 1'b1 || B_RESP !== r2) begin
            errors++;
            $display("FAIL bp_second_b: got %b/%b want 1/%b", B_VALID, B_RESP, r2);
        end
        B_READY = 1'b1;
        @(negedge clk);
        B_READY = 1'b0;
        exp_rd = model_read(64'h10);
        axi_read(64'h10, 0, data, resp, lat);
        checks++;
        if ({resp, data} !== exp_rd) begin
            errors++;
            $display("FAIL bp_readback: got %b/%h want %b/%h", resp, data, exp_rd[33:32], exp_rd[31:0]);
        end
    endtask

    task automatic test_r_backpressure();
        logic [1:0] resp;
        logic [31:0] data;
        logic [33:0] exp_rd, exp_old;
        int lat;
        bit bad;
        resp = model_write(64'hC, 32'h5, 4'hF);
        axi_write(64'hC, 32'h5, 4'hF, 1, 1, 0, 0);
        wait_b(0, resp, lat);
        exp_rd = model_read(64'hC);
        AR_ADDR = 64'hC;
        AR_VALID = 1'b1;
        @(negedge clk);
        AR_ADDR = 64'h4;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (R_VALID !== 1'b1 || {R_RESP, R_DATA} !== exp_rd || AR_READY !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rbp_hold: R_VALID=%b R=%b/%h AR_READY=%b, want 1/%b/%h/0",
                     R_VALID, R_RESP, R_DATA, AR_READY, exp_rd[33:32], exp_rd[31:0]);
        end
        R_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0;
        checks++;
        if (R_VALID !== 1'b0 || AR_READY !== 1'b1) begin
            errors++;
            $display("FAIL rbp_release: got R_VALID=%b AR_READY=%b want 0/1", R_VALID, AR_READY);
        end
        exp_rd = model_read(64'h4);
        @(negedge clk);
        AR_VALID = 1'b0;
        checks++;
        if (R_VALID !== 1'b1 || {R_RESP, R_DATA} !== exp_rd) begin
            errors++;
            $display("FAIL rbp_next_ar: got %b %b/%h want 1 %b/%h", R_VALID, R_RESP, R_DATA,
                     exp_rd[33:32], exp_rd[31:0]);
        end
        R_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0;

        // AR handshake on the same edge as a commit to the same register.
        exp_old = model_read(64'hC);
        AW_ADDR = 64'hC; W_DATA = 32'h9; W_STRB = 4'hF;
        AW_VALID = 1'b1; W_VALID = 1'b1;
        @(negedge clk);
        AW_VALID = 1'b0; W_VALID = 1'b0;
        AR_ADDR = 64'hC; AR_VALID = 1'b1;
        @(negedge clk);
        AR_VALID = 1'b0;
        checks++;
        if (R_VALID !== 1'b1 || B_VALID !== 1'b1 || {R_RESP, R_DATA} !== exp_old) begin
            errors++;
            $display("FAIL same_edge: got R_VALID=%b B_VALID=%b R=%b/%h want 1 1 %b/%h",
                     R_VALID, B_VALID, R_RESP, R_DATA, exp_old[33:32], exp_old[31:0]);
        end
        resp = model_write(64'hC, 32'h9, 4'hF);
        R_READY = 1'b1; B_READY = 1'b1;
        @(negedge clk);
        R_READY = 1'b0; B_READY = 1'b0;
        exp_rd = model_read(64'hC);
        axi_read(64'hC, 0, data, resp, lat);
        checks++;
        if ({resp, data} !== exp_rd) begin
            errors++;
            $display("FAIL same_edge_after: got %b/%h want %b/%h", resp, data, exp_rd[33:32], exp_rd[31:0]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [31:0] d, data;
        logic [3:0] s;
        logic [1:0] resp, exp_resp;
        logic [33:0] exp_rd;
        int lat;
        for (int it = 0; it < 60; it++) begin
            a = 64'($urandom_range(0, NR + 1)) * 4 + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (64'h1 << $urandom_range(5, 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_resp = model_write(a, d, s);
                axi_write(a, d, s, 1, 1, $urandom_range(0, 3), $urandom_range(0, 3));
                wait_b($urandom_range(0, 2), resp, lat);
                checks++;
                if (resp !== exp_resp || lat != 2 || o_regs !== exp_regs()) begin
                    errors++;
                    $display("FAIL rnd_write it=%0d addr=%h: got resp=%b lat=%0d regs=%h, want %b 2 %h",
                             it, a, resp, lat, o_regs, exp_resp, exp_regs());
                end
            end else begin
                exp_rd = model_read(a);
                axi_read(a, $urandom_range(0, 2), data, resp, lat);
                checks++;
                if ({resp, data} !== exp_rd || lat != 1) begin
                    errors++;
                    $display("FAIL rnd_read it=%0d addr=%h: got %b/%h lat=%0d want %b/%h lat=1",
                             it, a, resp, data, lat, exp_rd[33:32], exp_rd[31:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp, exp_resp;
        int lat;
        bit bad;
        // Leave AW held (no W) and a read response pending.
        AW_ADDR = 64'h18; AW_VALID = 1'b1;
        AR_ADDR = 64'h4;  AR_VALID = 1'b1;
        @(negedge clk);
        AW_VALID = 1'b0; AR_VALID = 1'b0;
        W_DATA = 32'hFEED_FACE; W_STRB = 4'hF; W_VALID = 1'b1;
        #2 arst = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({B_VALID, R_VALID, B_RESP, R_RESP} !== 6'b0 || R_DATA !== 32'h0 || o_wr_pulse !== '0) begin
            errors++;
            $display("FAIL async_reset: got B_VALID=%b R_VALID=%b R_DATA=%h pulse=%b, want 0",
                     B_VALID, R_VALID, R_DATA, o_wr_pulse);
        end
        checks++;
        if (o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL async_reset_regs: got %h want %h", o_regs, exp_regs());
        end
        W_VALID = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if ({AW_READY, W_READY, AR_READY} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 111", {AW_READY, W_READY, AR_READY});
        end
        axi_write(64'h0, 32'h0000_A5A5, 4'h3, 0, 1, 0, 0);
        bad = 0;
        repeat (4) begin
            if (B_VALID !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_spurious_b: got B_VALID=1 after reset with only W held, want 0");
        end
        exp_resp = model_write(64'h4, 32'h0000_A5A5, 4'h3);
        axi_write(64'h4, 32'h0, 4'h0, 1, 0, 0, 0);
        wait_b(0, resp, lat);
        checks++;
        if (resp !== exp_resp || lat != 2 || o_regs !== exp_regs()) begin
            errors++;
            $display("FAIL post_reset_write: got resp=%b lat=%0d regs=%h want %b 2 %h",
                     resp, lat, o_regs, exp_resp, exp_regs());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_slverr();
        test_b_backpressure();
        test_r_backpressure();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
